// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl: pops bytes from a receive buffer and echoes them to a UART
// transmitter, tracking the printable length of the current line.
// CR is echoed as CR LF and closes the line; LF and other control bytes are
// dropped; printables past MAX_LINE are answered with BEL (0x07).
// Optional feature macro: UART_ECHO_BS_EN -- when defined, BS/DEL rub out the
// last echoed character with BS SP BS (BEL on an empty line).
module uart_echo_ctrl #(
    parameter int MAX_LINE = 64
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_get,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [7:0] line_len,
    output logic       line_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    localparam logic [7:0] MAX_LEN = 8'(MAX_LINE);
    // Five cycles in WAIT_ACK without busy (counts 0..4) before re-issuing,
    // which gives a six-cycle re-issue period including the ISSUE cycle.
    localparam logic [2:0] ACK_LAST = 3'd4;

    state_t     state, state_nx;
    logic [7:0] rx_byte;
    logic [7:0] q0, q1, q2;
    logic [1:0] q_cnt;
    logic       q_is_cr;
    logic [2:0] ack_cnt;

    logic [1:0] dec_cnt;
    logic [7:0] dec_b0, dec_b1, dec_b2;
    logic       dec_cr, len_inc, len_dec;

    // Classify the latched byte into the echo sequence and line_len update
    always_comb begin
        dec_cnt = 2'd0;
        dec_b0  = rx_byte;
        dec_b1  = 8'h0A;
        dec_b2  = 8'h08;
        dec_cr  = 1'b0;
        len_inc = 1'b0;
        len_dec = 1'b0;
        if (rx_byte >= 8'h20 && rx_byte <= 8'h7E) begin
            dec_cnt = 2'd1;
            if (line_len < MAX_LEN) len_inc = 1'b1;
            else                    dec_b0  = 8'h07;
        end else if (rx_byte == 8'h0D) begin
            dec_cnt = 2'd2;
            dec_cr  = 1'b1;
        end
`ifdef UART_ECHO_BS_EN
        else if (rx_byte == 8'h08 || rx_byte == 8'h7F) begin
            if (line_len != 8'd0) begin
                dec_cnt = 2'd3;
                dec_b0  = 8'h08;
                dec_b1  = 8'h20;
                dec_b2  = 8'h08;
                len_dec = 1'b1;
            end else begin
                dec_cnt = 2'd1;
                dec_b0  = 8'h07;
            end
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!rx_empty) state_nx = DECODE;
            DECODE:    state_nx = (dec_cnt != 2'd0) ? ISSUE : IDLE;
            ISSUE:     if (!tx_busy) state_nx = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy)                  state_nx = WAIT_DONE;
                else if (ack_cnt == ACK_LAST) state_nx = ISSUE;
            end
            WAIT_DONE: if (!tx_busy) state_nx = (q_cnt == 2'd1) ? IDLE : ISSUE;
            default:   state_nx = IDLE;
        endcase
    end

    // Handshake outputs; rx_get is held low while reset is asserted
    always_comb begin
        rx_get    = resetn && (state == IDLE) && !rx_empty;
        tx_start  = (state == ISSUE) && !tx_busy;
        line_done = (state == WAIT_DONE) && !tx_busy && (q_cnt == 2'd1) && q_is_cr;
    end

    // Input latch, output queue, transmit byte and line length
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_byte  <= 8'h00;
            q0       <= 8'h00;
            q1       <= 8'h00;
            q2       <= 8'h00;
            q_cnt    <= 2'd0;
            q_is_cr  <= 1'b0;
            tx_data  <= 8'h00;
            line_len <= 8'd0;
        end else begin
            if (rx_get) rx_byte <= rx_data;
            case (state)
                DECODE: begin
                    q0      <= dec_b0;
                    q1      <= dec_b1;
                    q2      <= dec_b2;
                    q_cnt   <= dec_cnt;
                    q_is_cr <= dec_cr;
                    if (dec_cnt != 2'd0) tx_data <= dec_b0;
                    if (len_inc)      line_len <= line_len + 8'd1;
                    else if (len_dec) line_len <= line_len - 8'd1;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        q0    <= q1;
                        q1    <= q2;
                        q_cnt <= q_cnt - 2'd1;
                        if (q_cnt > 2'd1) tx_data <= q1;
                        if (q_cnt == 2'd1 && q_is_cr) line_len <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // WAIT_ACK timeout counter, cleared whenever we are not waiting for busy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                ack_cnt <= 3'd0;
        else if (state == WAIT_ACK) ack_cnt <= ack_cnt + 3'd1;
        else                        ack_cnt <= 3'd0;
    end

endmodule
